// File: rtl/rhythm_judge_multi.sv
// Multi-lane rhythm judge: scrolls one note map per lane on tick, judges
// synchronized button presses against a hit window and keeps score/combo stats.
module rhythm_judge_multi #(
  parameter int LANES   = 4,
  parameter int MAP_LEN = 192,
  parameter int WINDOW  = 1,
  parameter int SCORE_W = 12,
  parameter int COMBO_W = 8,
  parameter int VIEW    = 10,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       load,
  input  logic                       start,
  input  logic [LANES*MAP_LEN-1:0]   map_in,
  input  logic [LANES-1:0]           buttons,
  output logic [LANES*VIEW-1:0]      lane_view,
  output logic [SCORE_W-1:0]         score,
  output logic [COMBO_W-1:0]         combo,
  output logic [COMBO_W-1:0]         max_combo,
  output logic [1:0]                 judge,
  output logic [LW-1:0]              judge_lane,
  output logic                       judge_valid,
  output logic [1:0]                 state
);

  localparam int P  = WINDOW + 1;
  localparam int WW = 2 * WINDOW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [MAP_LEN-1:0]   map_q [LANES];
  logic [MAP_LEN-1:0]   map_d [LANES];
  logic [MAP_LEN-1:0]   map_in_lane [LANES];
  logic [VIEW-1:0]      view_q [LANES];
  logic [VIEW-1:0]      view_d [LANES];
  logic [LANES-1:0]     sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [LANES-1:0]     pend_q, pend_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d, max_q, max_d;
  logic [1:0]           judge_q, judge_d;
  logic [LW-1:0]        jlane_q, jlane_d;
  logic                 jvalid_q, jvalid_d;

  logic [LANES-1:0]     fall, miss, svc_onehot;
  logic [LW-1:0]        svc_lane, miss_lane;
  logic                 all_zero;
  logic [WW-1:0]        win, clr_win;
  logic [MAP_LEN-1:0]   clr_mask;
  logic                 hit_found, hit_perfect;
  logic [2:0]           mult;
  logic [3:0]           add;
  logic [SCORE_W:0]     sum;
  logic [SCORE_W-1:0]   score_hit;
  logic [COMBO_W-1:0]   combo_inc;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign map_in_lane[gi]               = map_in[gi*MAP_LEN +: MAP_LEN];
    assign lane_view[gi*VIEW +: VIEW]    = view_q[gi];
    assign miss[gi]                      = map_q[gi][0];
  end

  // Lowest pending lane is serviced; win holds its slots 1..P+WINDOW.
  always_comb begin
    fall       = sync3_q & ~sync2_q;
    svc_onehot = '0;
    svc_lane   = '0;
    miss_lane  = '0;
    win        = '0;
    all_zero   = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        svc_onehot    = '0;
        svc_onehot[i] = 1'b1;
        svc_lane      = LW'(i);
      end
      if (miss[i]) miss_lane = LW'(i);
    end
    for (int i = 0; i < LANES; i++) begin
      if (svc_onehot[i]) win = map_q[i][P+WINDOW:1];
      if (map_q[i] != '0) all_zero = 1'b0;
    end
  end

  // Slot P maps to win[WINDOW]; search P, then P-d before P+d.
  always_comb begin
    clr_win     = '0;
    hit_found   = 1'b0;
    hit_perfect = 1'b0;
    if (win[WINDOW]) begin
      hit_found        = 1'b1;
      hit_perfect      = 1'b1;
      clr_win[WINDOW]  = 1'b1;
    end
    for (int d = 1; d <= WINDOW; d++) begin
      if (!hit_found && win[WINDOW-d]) begin
        hit_found          = 1'b1;
        clr_win[WINDOW-d]  = 1'b1;
      end
      if (!hit_found && win[WINDOW+d]) begin
        hit_found          = 1'b1;
        clr_win[WINDOW+d]  = 1'b1;
      end
    end
    clr_mask = MAP_LEN'({clr_win, 1'b0});
  end

  always_comb begin
    if (combo_q >= COMBO_W'(30))      mult = 3'd4;
    else if (combo_q >= COMBO_W'(20)) mult = 3'd3;
    else if (combo_q >= COMBO_W'(10)) mult = 3'd2;
    else                              mult = 3'd1;
    add       = hit_perfect ? {mult, 1'b0} : {1'b0, mult};
    sum       = {1'b0, score_q} + (SCORE_W+1)'(add);
    score_hit = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    combo_inc = (&combo_q) ? combo_q : combo_q + COMBO_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    score_d  = score_q;
    combo_d  = combo_q;
    max_d    = max_q;
    judge_d  = judge_q;
    jlane_d  = jlane_q;
    jvalid_d = 1'b0;
    sync1_d  = buttons;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    for (int i = 0; i < LANES; i++) begin
      map_d[i]  = map_q[i];
      view_d[i] = map_q[i][VIEW:1];
    end
    if (load) begin
      state_d = S_IDLE;
      pend_d  = '0;
      score_d = '0;
      combo_d = '0;
      max_d   = '0;
      judge_d = 2'b00;
      jlane_d = '0;
      for (int i = 0; i < LANES; i++) map_d[i] = map_in_lane[i];
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          pend_d = '0;
          if (start) state_d = S_PLAY;
        end
        S_DONE: pend_d = '0;
        S_PLAY: begin
          // OR-ing the edge in drops a press on an already pending lane.
          pend_d = pend_q | fall;
          if (start)         state_d = S_PAUSE;
          else if (all_zero) state_d = S_DONE;
          if (tick) begin
            for (int i = 0; i < LANES; i++) map_d[i] = {1'b0, map_q[i][MAP_LEN-1:1]};
            if (|miss) begin
              combo_d  = '0;
              judge_d  = 2'b11;
              jlane_d  = miss_lane;
              jvalid_d = 1'b1;
            end
          end else if (|pend_q) begin
            pend_d   = (pend_q | fall) & ~svc_onehot;
            jlane_d  = svc_lane;
            jvalid_d = 1'b1;
            for (int i = 0; i < LANES; i++) begin
              if (svc_onehot[i]) map_d[i] = map_q[i] & ~clr_mask;
            end
            if (hit_found) begin
              judge_d = hit_perfect ? 2'b01 : 2'b10;
              score_d = score_hit;
              combo_d = combo_inc;
              max_d   = (combo_inc > max_q) ? combo_inc : max_q;
            end else begin
              judge_d = 2'b00;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= '1;
      sync2_q  <= '1;
      sync3_q  <= '1;
      pend_q   <= '0;
      score_q  <= '0;
      combo_q  <= '0;
      max_q    <= '0;
      judge_q  <= 2'b00;
      jlane_q  <= '0;
      jvalid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        map_q[i]  <= '0;
        view_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      pend_q   <= pend_d;
      score_q  <= score_d;
      combo_q  <= combo_d;
      max_q    <= max_d;
      judge_q  <= judge_d;
      jlane_q  <= jlane_d;
      jvalid_q <= jvalid_d;
      for (int i = 0; i < LANES; i++) begin
        map_q[i]  <= map_d[i];
        view_q[i] <= view_d[i];
      end
    end
  end

  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign judge       = judge_q;
  assign judge_lane  = jlane_q;
  assign judge_valid = jvalid_q;
  assign state       = state_q;

endmodule

// File: tb/tb_rhythm_judge_multi.sv
// Bench for rhythm_judge_multi (2 lanes, 16-slot maps, window 1): vector table
// plus hand-written sequences; judgements are scoreboarded on judge_valid.
module tb_rhythm_judge_multi;
  localparam int LANES = 2, MAP_LEN = 16, WINDOW = 1, SCORE_W = 12, COMBO_W = 8, VIEW = 10;

  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0;
  logic [LANES*MAP_LEN-1:0] map_in = '0;
  logic [LANES-1:0] buttons = '1;
  logic [LANES*VIEW-1:0] lane_view;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo, max_combo;
  logic [1:0] judge, state;
  logic [0:0] judge_lane;
  logic judge_valid;

  always #10 clk = ~clk;

  rhythm_judge_multi #(.LANES(LANES), .MAP_LEN(MAP_LEN), .WINDOW(WINDOW),
                       .SCORE_W(SCORE_W), .COMBO_W(COMBO_W), .VIEW(VIEW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .start(start),
    .map_in(map_in), .buttons(buttons), .lane_view(lane_view),
    .score(score), .combo(combo), .max_combo(max_combo), .judge(judge),
    .judge_lane(judge_lane), .judge_valid(judge_valid), .state(state)
  );

  typedef struct packed {
    logic [1:0]  judge;
    logic [0:0]  lane;
    logic [11:0] score;
    logic [7:0]  combo;
    logic [7:0]  maxc;
  } exp_t;

  typedef struct {
    logic [15:0] m0, m1;
    logic [1:0]  mask;
    logic [1:0]  judge;
    int          lane, score, combo;
    logic [9:0]  v0, v1;
    logic [1:0]  st;
  } vec_t;

  exp_t exp_q[$];
  int   pulse_cyc[$];
  int   n_vec = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && judge_valid) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_judgement: got judge=%0d lane=%0d expected no pulse", judge, judge_lane);
      end else begin
        e = exp_q.pop_front();
        chk("judge", 32'(judge), 32'(e.judge));
        chk("judge_lane", 32'(judge_lane), 32'(e.lane));
        chk("score", 32'(score), 32'(e.score));
        chk("combo", 32'(combo), 32'(e.combo));
        chk("max_combo", 32'(max_combo), 32'(e.maxc));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] m0, input logic [15:0] m1);
    map_in = {m1, m0};
    load = 1'b1; step(1); load = 1'b0; step(1);
  endtask

  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0; step(1);
  endtask

  task automatic do_tick();
    tick = 1'b1; step(1); tick = 1'b0; step(3);
  endtask

  task automatic press(input logic [1:0] mask);
    buttons = ~mask; step(3); buttons = '1; step(6);
  endtask

  task automatic push(input logic [1:0] j, input int l, input int s, input int c, input int m);
    exp_t e;
    e.judge = j; e.lane = 1'(l); e.score = 12'(s); e.combo = 8'(c); e.maxc = 8'(m);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: got %0d judgements missing expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected bench completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vt[9];
    vt[0] = '{16'h0004, 16'h0000, 2'b01, 2'b01, 0, 2, 1, 10'h000, 10'h000, 2'b11};
    vt[1] = '{16'h0008, 16'h0000, 2'b01, 2'b10, 0, 1, 1, 10'h000, 10'h000, 2'b11};
    vt[2] = '{16'h0002, 16'h0000, 2'b01, 2'b10, 0, 1, 1, 10'h000, 10'h000, 2'b11};
    vt[3] = '{16'h000E, 16'h0000, 2'b01, 2'b01, 0, 2, 1, 10'h005, 10'h000, 2'b01};
    vt[4] = '{16'h000A, 16'h0000, 2'b01, 2'b10, 0, 1, 1, 10'h004, 10'h000, 2'b01};
    vt[5] = '{16'h0011, 16'h0000, 2'b01, 2'b00, 0, 0, 0, 10'h008, 10'h000, 2'b01};
    vt[6] = '{16'h0100, 16'h0004, 2'b10, 2'b01, 1, 2, 1, 10'h080, 10'h000, 2'b01};
    vt[7] = '{16'h0000, 16'h0001, 2'b10, 2'b00, 1, 0, 0, 10'h000, 10'h000, 2'b01};
    vt[8] = '{16'h8000, 16'h0400, 2'b01, 2'b00, 0, 0, 0, 10'h000, 10'h200, 2'b01};

    // reset values
    step(3);
    chk("rst_score", 32'(score), 0);
    chk("rst_combo", 32'(combo), 0);
    chk("rst_max", 32'(max_combo), 0);
    chk("rst_judge", 32'(judge), 0);
    chk("rst_jlane", 32'(judge_lane), 0);
    chk("rst_jvalid", 32'(judge_valid), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_view", 32'(lane_view), 0);
    rst = 1'b1;
    step(2);

    for (int i = 0; i < 9; i++) begin
      do_load(vt[i].m0, vt[i].m1);
      do_start();
      push(vt[i].judge, vt[i].lane, vt[i].score, vt[i].combo, vt[i].combo);
      press(vt[i].mask);
      step(2);
      chk($sformatf("v%0d_view0", i), 32'(lane_view[9:0]), 32'(vt[i].v0));
      chk($sformatf("v%0d_view1", i), 32'(lane_view[19:10]), 32'(vt[i].v1));
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vt[i].st));
      drain($sformatf("v%0d_drain", i));
    end

    // hit then tick miss on lane 1 clears combo but keeps max
    do_load(16'h0004, 16'h0001);
    do_start();
    push(2'b01, 0, 2, 1, 1);
    press(2'b01);
    push(2'b11, 1, 2, 0, 1);
    do_tick();
    chk("miss_state_done", 32'(state), 3);
    drain("miss_drain");

    // simultaneous misses on both lanes give a single pulse, lowest lane
    do_load(16'h0001, 16'h0001);
    do_start();
    push(2'b11, 0, 0, 0, 0);
    do_tick();
    drain("dual_miss_drain");

    // both buttons in the same cycle: two consecutive pulses, lane 0 first
    do_load(16'h0004, 16'h0004);
    do_start();
    push(2'b01, 0, 2, 1, 1);
    push(2'b01, 1, 4, 2, 2);
    pulse_cyc.delete();
    press(2'b11);
    chk("dual_pulse_count", 32'(pulse_cyc.size()), 2);
    if (pulse_cyc.size() == 2) chk("dual_pulse_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 1);
    drain("dual_drain");

    // 12 perfect hits cross the x2 multiplier, then a lane-1 miss
    do_load(16'h3FFC, 16'h0800);
    do_start();
    for (int k = 1; k <= 12; k++) begin
      push(2'b01, 0, (k <= 10) ? 2 * k : 20 + 4 * (k - 10), k, k);
      press(2'b01);
      if (k < 12) do_tick();
    end
    push(2'b11, 1, 28, 0, 12);
    do_tick();
    chk("streak_score", 32'(score), 28);
    chk("streak_max", 32'(max_combo), 12);
    chk("streak_combo", 32'(combo), 0);
    chk("streak_state", 32'(state), 3);
    drain("streak_drain");

    // press during PAUSE is discarded and not serviced after resume
    do_load(16'h0004, 16'h0000);
    do_start();
    do_start();
    chk("pause_state", 32'(state), 2);
    press(2'b01);
    do_start();
    step(4);
    chk("resume_state", 32'(state), 1);
    chk("resume_view0", 32'(lane_view[9:0]), 32'h002);
    push(2'b01, 0, 2, 1, 1);
    press(2'b01);
    drain("pause_drain");

    // pending press meeting a tick is deferred and judged on the shifted map
    do_load(16'h0008, 16'h0000);
    do_start();
    push(2'b01, 0, 2, 1, 1);
    buttons = 2'b10;
    step(2);
    step(1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    buttons = '1;
    step(5);
    chk("defer_view0", 32'(lane_view[9:0]), 0);
    chk("defer_state", 32'(state), 3);
    drain("defer_drain");

    // reset in the middle of play, then a tick in IDLE is ignored
    do_load(16'h0004, 16'h0040);
    do_start();
    push(2'b01, 0, 2, 1, 1);
    press(2'b01);
    chk("pre_rst_state", 32'(state), 1);
    rst = 1'b0;
    step(1);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_combo", 32'(combo), 0);
    chk("mid_rst_max", 32'(max_combo), 0);
    chk("mid_rst_judge", 32'(judge), 0);
    chk("mid_rst_jlane", 32'(judge_lane), 0);
    chk("mid_rst_jvalid", 32'(judge_valid), 0);
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_view", 32'(lane_view), 0);
    rst = 1'b1;
    step(1);
    do_tick();
    chk("post_rst_tick_state", 32'(state), 0);
    chk("post_rst_tick_view", 32'(lane_view), 0);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
